// File: rtl/strob_seq.sv
// Microstep timing sequencer: Moore FSM producing mutually exclusive
// STROB1 / STROB2 / GOT phase pulses, with single-step and memory-wait support.
module strob_seq #(
    parameter int unsigned S1_CYCLES  = 2,
    parameter int unsigned S2_CYCLES  = 2,
    parameter int unsigned GOT_CYCLES = 1,
    parameter int unsigned WAIT_MAX   = 255
) (
    input  logic       clk_sys,
    input  logic       clr_,
    input  logic       run,
    input  logic       step,
    input  logic       sl,
    input  logic       wm,
    input  logic       mem_ok,
    output logic       strob1,
    output logic       strob2,
    output logic       got,
    output logic       busy,
    output logic       alarm,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        S1   = 3'd1,
        S2   = 3'd2,
        GOT  = 3'd3,
        WAIT = 3'd4
    } state_t;

    localparam logic [3:0] S1_LAST   = 4'(S1_CYCLES - 1);
    localparam logic [3:0] S2_LAST   = 4'(S2_CYCLES - 1);
    localparam logic [3:0] GOT_LAST  = 4'(GOT_CYCLES - 1);
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    state_t     state;
    state_t     state_nx;
    logic [3:0] cnt;
    logic [7:0] wcnt;
    logic       step_q;
    logic       step_edge;
    logic       timeout;

    assign step_edge = step & ~step_q;

    always_ff @(posedge clk_sys or negedge clr_) begin
        if (!clr_) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        timeout  = 1'b0;
        case (state)
            IDLE: begin
                if (run || step_edge) state_nx = S1;
            end
            S1: begin
                if (cnt == S1_LAST) state_nx = sl ? S2 : GOT;
            end
            S2: begin
                if (cnt == S2_LAST) state_nx = GOT;
            end
            GOT: begin
                if (cnt == GOT_LAST) begin
                    if (wm)       state_nx = WAIT;
                    else if (run) state_nx = S1;
                    else          state_nx = IDLE;
                end
            end
            WAIT: begin
                // mem_ok takes priority over the timeout on the final wait clock
                if (mem_ok) begin
                    state_nx = run ? S1 : IDLE;
                end else if (wcnt == WAIT_LAST) begin
                    state_nx = IDLE;
                    timeout  = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        strob1 = (state == S1);
        strob2 = (state == S2);
        got    = (state == GOT);
        busy   = (state != IDLE);
        phase  = state;
    end

    always_ff @(posedge clk_sys or negedge clr_) begin
        if (!clr_) begin
            cnt  <= '0;
            wcnt <= '0;
        end else if (state_nx != state) begin
            cnt  <= '0;
            wcnt <= '0;
        end else if (state == WAIT) begin
            wcnt <= wcnt + 8'd1;
        end else if (state != IDLE) begin
            cnt  <= cnt + 4'd1;
        end
    end

    always_ff @(posedge clk_sys or negedge clr_) begin
        if (!clr_) begin
            step_q <= 1'b0;
            alarm  <= 1'b0;
        end else begin
            step_q <= step;
            if (timeout) begin
                alarm <= 1'b1;
            end else if (state == IDLE && state_nx == S1) begin
                alarm <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_strob_seq.sv
// Directed bench for strob_seq: expected phase/alarm per clock are queued with
// the stimulus and compared one entry per clock as the sequencer advances.
module tb_strob_seq;

    logic       clk_sys;
    logic       clr_;
    logic       run;
    logic       step;
    logic       sl;
    logic       wm;
    logic       mem_ok;
    logic       strob1;
    logic       strob2;
    logic       got;
    logic       busy;
    logic       alarm;
    logic [2:0] phase;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    typedef struct packed {
        logic [2:0] ph;
        logic       al;
    } exp_t;

    exp_t sb[$];

    strob_seq #(
        .S1_CYCLES (2),
        .S2_CYCLES (2),
        .GOT_CYCLES(1),
        .WAIT_MAX  (8)
    ) dut (
        .clk_sys(clk_sys),
        .clr_   (clr_),
        .run    (run),
        .step   (step),
        .sl     (sl),
        .wm     (wm),
        .mem_ok (mem_ok),
        .strob1 (strob1),
        .strob2 (strob2),
        .got    (got),
        .busy   (busy),
        .alarm  (alarm),
        .phase  (phase)
    );

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, required finish before 200000 time units");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_strob1"}, {7'd0, strob1}, 8'd0);
        check({tag, "_strob2"}, {7'd0, strob2}, 8'd0);
        check({tag, "_got"},    {7'd0, got},    8'd0);
        check({tag, "_busy"},   {7'd0, busy},   8'd0);
        check({tag, "_alarm"},  {7'd0, alarm},  8'd0);
        check({tag, "_phase"},  {5'd0, phase},  8'd0);
    endtask

    task automatic push(input logic [2:0] ph, input logic al, input int unsigned n);
        exp_t e;
        e.ph = ph;
        e.al = al;
        for (int unsigned i = 0; i < n; i++) sb.push_back(e);
    endtask

    task automatic drain(input string tag);
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clk_sys);
            #1;
            check({tag, "_phase"},  {5'd0, phase},  {5'd0, e.ph});
            check({tag, "_strob1"}, {7'd0, strob1}, {7'd0, (e.ph == 3'd1)});
            check({tag, "_strob2"}, {7'd0, strob2}, {7'd0, (e.ph == 3'd2)});
            check({tag, "_got"},    {7'd0, got},    {7'd0, (e.ph == 3'd3)});
            check({tag, "_busy"},   {7'd0, busy},   {7'd0, (e.ph != 3'd0)});
            check({tag, "_alarm"},  {7'd0, alarm},  {7'd0, e.al});
        end
    endtask

    initial begin
        clr_ = 1'b0; run = 1'b0; step = 1'b0; sl = 1'b0; wm = 1'b0; mem_ok = 1'b0;
        #2;
        check_zero("rst_hold");
        #21;
        clr_ = 1'b1;

        // 1: reset asserted mid-S2, then idle with no requests
        run = 1'b1; sl = 1'b1;
        push(3'd1, 1'b0, 2); push(3'd2, 1'b0, 1);
        drain("t1_to_s2");
        #2;
        clr_ = 1'b0;
        #1;
        check_zero("t1_async_rst");
        run = 1'b0; sl = 1'b0;
        #2;
        clr_ = 1'b1;
        push(3'd0, 1'b0, 20);
        drain("t1_idle");

        // 2: continuous short microsteps, run dropped in the fifth
        run = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push(3'd1, 1'b0, 2); push(3'd3, 1'b0, 1);
        end
        push(3'd1, 1'b0, 2);
        drain("t2_run");
        run = 1'b0;
        push(3'd3, 1'b0, 1); push(3'd0, 1'b0, 2);
        drain("t2_stop");

        // 3: long microstep followed by a short one
        run = 1'b1; sl = 1'b0;
        push(3'd1, 1'b0, 2);
        drain("t3_s1");
        sl = 1'b1;
        push(3'd2, 1'b0, 1);
        drain("t3_s2a");
        sl = 1'b0;
        push(3'd2, 1'b0, 1); push(3'd3, 1'b0, 1); push(3'd1, 1'b0, 2);
        drain("t3_long");
        run = 1'b0;
        push(3'd3, 1'b0, 1); push(3'd0, 1'b0, 1);
        drain("t3_short");

        // 4: single step, held step, step while busy, step after idle
        step = 1'b1;
        push(3'd1, 1'b0, 2); push(3'd3, 1'b0, 1); push(3'd0, 1'b0, 7);
        drain("t4_held");
        step = 1'b0;
        push(3'd0, 1'b0, 2);
        drain("t4_rel");
        step = 1'b1; push(3'd1, 1'b0, 1); drain("t4_p1");
        step = 1'b0; push(3'd1, 1'b0, 1); drain("t4_p1b");
        step = 1'b1; push(3'd3, 1'b0, 1); drain("t4_busy_edge");
        step = 1'b0; push(3'd0, 1'b0, 2); drain("t4_ignored");
        step = 1'b1; push(3'd1, 1'b0, 1); drain("t4_p2");
        step = 1'b0;
        push(3'd1, 1'b0, 1); push(3'd3, 1'b0, 1); push(3'd0, 1'b0, 1);
        drain("t4_p2b");

        // 5: memory wait released by mem_ok after 7 wait clocks, run held
        run = 1'b1;
        push(3'd1, 1'b0, 2); drain("t5_s1");
        wm = 1'b1;
        push(3'd3, 1'b0, 1); drain("t5_got");
        push(3'd4, 1'b0, 1); drain("t5_wait1");
        wm = 1'b0;
        push(3'd4, 1'b0, 6); drain("t5_wait");
        mem_ok = 1'b1;
        push(3'd1, 1'b0, 1); drain("t5_resume");
        mem_ok = 1'b0;
        push(3'd1, 1'b0, 1); drain("t5_s1b");
        run = 1'b0;
        push(3'd3, 1'b0, 1); push(3'd0, 1'b0, 1);
        drain("t5_end");

        // 6a: wait timeout sets a sticky alarm, cleared by the next S1 entry
        step = 1'b1; push(3'd1, 1'b0, 1); drain("t6_start");
        step = 1'b0; push(3'd1, 1'b0, 1); drain("t6_s1");
        wm = 1'b1;   push(3'd3, 1'b0, 1); drain("t6_got");
        push(3'd4, 1'b0, 1); drain("t6_wait1");
        wm = 1'b0;
        push(3'd4, 1'b0, 7); drain("t6_wait");
        push(3'd0, 1'b1, 3); drain("t6_alarm");
        step = 1'b1; push(3'd1, 1'b0, 1); drain("t6_clear");
        step = 1'b0;
        push(3'd1, 1'b0, 1); push(3'd3, 1'b0, 1); push(3'd0, 1'b0, 1);
        drain("t6_after");

        // 6b: mem_ok arriving on the final wait clock wins over the timeout
        step = 1'b1; push(3'd1, 1'b0, 1); drain("t6b_start");
        step = 1'b0; push(3'd1, 1'b0, 1); drain("t6b_s1");
        wm = 1'b1;   push(3'd3, 1'b0, 1); drain("t6b_got");
        push(3'd4, 1'b0, 1); drain("t6b_wait1");
        wm = 1'b0;
        push(3'd4, 1'b0, 7); drain("t6b_wait");
        mem_ok = 1'b1;
        push(3'd0, 1'b0, 1); drain("t6b_edge");
        mem_ok = 1'b0;
        push(3'd0, 1'b0, 2); drain("t6b_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/strob_seq.md
Name: strob_seq

Overview:
- Microstep timing sequencer for the control unit.
- Generates registered, glitch-free STROB1, STROB2 and GOT phase pulses.
- The flag register and other W-bus consumers qualify their ust_*/w_* commands with these pulses.
- Supports continuous run, control-panel single-step, long/short microsteps, and a memory-wait phase with timeout alarm.

Parameters:
S1_CYCLES, 2, clocks strob1 stays high per microstep (1..15)
S2_CYCLES, 2, clocks strob2 stays high in a long microstep (1..15)
GOT_CYCLES, 1, clocks got stays high per microstep (1..15)
WAIT_MAX, 255, clocks allowed in memory wait before alarm (1..255)

Ports:
clk_sys  in  1  system clock, all state on rising edge
clr_  in  1  reset, asynchronous, active-low
run  in  1  continuous sequencing enable (level)
step  in  1  panel single-step request; rising edge detected internally
sl  in  1  long-microstep request; sampled on last strob1 clock
wm  in  1  memory-wait request; sampled on last got clock
mem_ok  in  1  memory transaction done (level)
strob1  out  1  phase-1 strobe
strob2  out  1  phase-2 strobe
got  out  1  end-of-microstep strobe
busy  out  1  high in any state except IDLE
alarm  out  1  memory-wait timeout flag (sticky)
phase  out  3  state code: IDLE=0, S1=1, S2=2, GOT=3, WAIT=4

Behaviour:
- clr_ low, asynchronously: state IDLE, counter 0, all outputs 0, step edge register 0. Same when asserted mid-microstep; no partial strobe continues.
- All outputs decoded from registered state (Moore): strob1 = (state==S1), strob2 = (state==S2), got = (state==GOT). Strobes are mutually exclusive, never high in the same clock.
- 4-bit phase counter cnt, cleared on every state entry. WAIT uses an 8-bit counter.
- IDLE:
  - run=1 → S1 next clock.
  - else step rising edge (step=1, previous step=0) → S1.
  - Entry to S1 from IDLE clears alarm.
- S1: held S1_CYCLES clocks. On the last one, sl=1 → S2, else → GOT.
- S2: held S2_CYCLES clocks → GOT.
- GOT: held GOT_CYCLES clocks. On the last one:
  - wm=1 → WAIT.
  - else run=1 → S1 (back-to-back, no idle clock).
  - else → IDLE.
- WAIT: stays until mem_ok=1, then:
  - run=1 → S1.
  - else → IDLE.
  - If mem_ok is still 0 after WAIT_MAX clocks in WAIT: alarm←1, → IDLE.
  - mem_ok=1 on the same clock the count reaches WAIT_MAX: mem_ok wins, no alarm.
- run dropping mid-microstep does not truncate it; the current microstep completes through GOT (and WAIT), then IDLE.
- step edges while busy are ignored and not queued.
- step held high does not retrigger; it must return low before the next edge.
- Cycle length:
  - short microstep = S1_CYCLES + GOT_CYCLES clocks.
  - long = S1_CYCLES + S2_CYCLES + GOT_CYCLES clocks, plus WAIT dwell.
- alarm: set only by timeout. Cleared by clr_ or by the next S1 entry from IDLE.
- phase codes 5-7 are unreachable. An illegal state recovers to IDLE on the next clock.

Test Plan:
1. Reset/idle: clr_ low mid-S2 with defaults → all outputs 0, phase=0 in the same cycle (async). Release with run=0, step=0 → stays IDLE 20 clocks.
2. Continuous short: run=1, sl=0, wm=0 → repeating pattern strob1 2 clk, got 1 clk, period 3, no gap. Check 5 periods; strob2 never high.
3. Long step: run=1, sl=1 on last strob1 clock only → strob1 2, strob2 2, got 1. The next microstep samples sl=0 → short (3 clocks).
4. Single-step: run=0, step held high 10 clocks → exactly one microstep, then IDLE. Second pulse inside busy window ignored. Pulse after IDLE → one more microstep.
5. Memory wait: wm=1 at got, mem_ok rises 7 clocks later, run=1 → phase=4 for 7 clocks, S1 on the clock after mem_ok; alarm stays 0.
6. Timeout: WAIT_MAX=8, wm=1, mem_ok=0 → IDLE after 8 WAIT clocks, alarm=1 until the next step edge starts S1. Also check mem_ok=1 exactly at count 8 → no alarm.
